// File: rtl/dvp_rgb565_capture.sv
// DVP capture: skips unstable frames after sensor init, packs byte pairs into RGB565 with X/Y, checks frame size.
// Latency: camera pins registered once; a pixel is presented one cycle after its low byte is registered.
// Backpressure: none; the camera cannot be stalled, so Pixel_Valid is a free-running strobe.
module dvp_rgb565_capture #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int SKIP_FRAMES  = 10,
    parameter int VSYNC_POL    = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init_Done,
    input  logic        camera_vsync,
    input  logic        camera_href,
    input  logic [7:0]  camera_data,
    output logic        Pixel_Valid,
    output logic [15:0] Pixel_Data,
    output logic [11:0] Pixel_X,
    output logic [11:0] Pixel_Y,
    output logic        Frame_Start,
    output logic        Frame_Done,
    output logic        Frame_Err,
    output logic [15:0] Frame_Cnt,
    output logic        Capturing
);
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;

    localparam logic [11:0] WIDTH_C  = 12'(IMAGE_WIDTH);
    localparam logic [11:0] HEIGHT_C = 12'(IMAGE_HEIGHT);
    localparam logic [7:0]  SKIP_C   = 8'(SKIP_FRAMES);

    state_t      state_q, state_d;
    logic        vs_q, hr_q, vb_prev_q;
    logic [7:0]  d_q;
    logic [7:0]  fb_cnt_q, fb_cnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        err_q, err_d;
    logic        open_q, open_d;      // a line has delivered bytes and not yet ended
    logic        pix_vld_q, pix_vld_d;
    logic [15:0] pix_dat_q, pix_dat_d;
    logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        fstart_q, fstart_d;
    logic        fdone_q, fdone_d;
    logic        ferr_q, ferr_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic        vb, fb, line_end, err_le;
    logic [11:0] y_le;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign vb = (VSYNC_POL != 0) ? vs_q : ~vs_q;
    assign fb = vb & ~vb_prev_q;

    // Next-state: init gating, frame skipping, byte pairing, line and frame bookkeeping.
    always_comb begin
        state_d   = state_q;
        fb_cnt_d  = fb_cnt_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;
        open_d    = open_q;
        pix_vld_d = 1'b0;
        pix_dat_d = pix_dat_q;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        fstart_d  = 1'b0;
        fdone_d   = 1'b0;
        ferr_d    = 1'b0;
        fcnt_d    = fcnt_q;
        line_end  = 1'b0;
        err_le    = err_q;
        y_le      = y_q;

        if (!Init_Done) begin
            // Abandon any partial frame; Frame_Cnt keeps its value.
            state_d = IDLE;
            phase_d = 1'b0;
            x_d     = 12'd0;
            y_d     = 12'd0;
            err_d   = 1'b0;
            open_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    fb_cnt_d = 8'd0;
                    state_d  = WAIT;
                end
                WAIT: begin
                    if (fb) begin
                        if (fb_cnt_q == SKIP_C) state_d = ACTIVE;
                        else                    fb_cnt_d = fb_cnt_q + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (hr_q && !vb) begin
                        open_d = 1'b1;
                        if (!phase_q) begin
                            hi_d    = d_q;
                            phase_d = 1'b1;
                        end else begin
                            pix_vld_d = 1'b1;
                            pix_dat_d = {hi_q, d_q};
                            pix_x_d   = x_q;
                            pix_y_d   = y_q;
                            fstart_d  = (x_q == 12'd0) && (y_q == 12'd0);
                            x_d       = sat_inc(x_q);
                            phase_d   = 1'b0;
                        end
                    end else if (!hr_q) begin
                        phase_d = 1'b0;
                    end

                    // A boundary arriving with href still high closes the line first.
                    line_end = open_q && (!hr_q || fb);
                    if (line_end) begin
                        if ((x_q != WIDTH_C) || phase_q) err_le = 1'b1;
                        x_d     = 12'd0;
                        y_le    = sat_inc(y_q);
                        phase_d = 1'b0;
                        open_d  = 1'b0;
                    end
                    err_d = err_le;
                    y_d   = y_le;

                    if (fb) begin
                        fdone_d = 1'b1;
                        ferr_d  = err_le || (y_le != HEIGHT_C);
                        fcnt_d  = fcnt_q + 16'd1;
                        x_d     = 12'd0;
                        y_d     = 12'd0;
                        err_d   = 1'b0;
                        phase_d = 1'b0;
                        open_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, input stage and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            vs_q      <= 1'b0;
            hr_q      <= 1'b0;
            d_q       <= 8'd0;
            vb_prev_q <= 1'b0;
            fb_cnt_q  <= 8'd0;
            phase_q   <= 1'b0;
            hi_q      <= 8'd0;
            x_q       <= 12'd0;
            y_q       <= 12'd0;
            err_q     <= 1'b0;
            open_q    <= 1'b0;
            pix_vld_q <= 1'b0;
            pix_dat_q <= 16'd0;
            pix_x_q   <= 12'd0;
            pix_y_q   <= 12'd0;
            fstart_q  <= 1'b0;
            fdone_q   <= 1'b0;
            ferr_q    <= 1'b0;
            fcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            vs_q      <= camera_vsync;
            hr_q      <= camera_href;
            d_q       <= camera_data;
            vb_prev_q <= vb;
            fb_cnt_q  <= fb_cnt_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            x_q       <= x_d;
            y_q       <= y_d;
            err_q     <= err_d;
            open_q    <= open_d;
            pix_vld_q <= pix_vld_d;
            pix_dat_q <= pix_dat_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            fstart_q  <= fstart_d;
            fdone_q   <= fdone_d;
            ferr_q    <= ferr_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign Pixel_Valid = pix_vld_q;
    assign Pixel_Data  = pix_dat_q;
    assign Pixel_X     = pix_x_q;
    assign Pixel_Y     = pix_y_q;
    assign Frame_Start = fstart_q;
    assign Frame_Done  = fdone_q;
    assign Frame_Err   = ferr_q;
    assign Frame_Cnt   = fcnt_q;
    assign Capturing   = (state_q == ACTIVE);

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Bench for dvp_rgb565_capture: table of frame shapes, hand sequences for abort/reset/latency, random frames.
// Expected pixels and frame results come from a frame-level model of the byte stream being driven.
// Inputs driven just after the falling edge; outputs sampled on the falling edge.
module tb_dvp_rgb565_capture;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int SKIP = 2;

    logic        Clk = 1'b0;
    logic        Rst, Init_Done, camera_vsync, camera_href;
    logic [7:0]  camera_data;
    logic        Pixel_Valid, Frame_Start, Frame_Done, Frame_Err, Capturing;
    logic [15:0] Pixel_Data, Frame_Cnt;
    logic [11:0] Pixel_X, Pixel_Y;

    dvp_rgb565_capture #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SKIP_FRAMES(SKIP), .VSYNC_POL(1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Init_Done(Init_Done),
        .camera_vsync(camera_vsync), .camera_href(camera_href), .camera_data(camera_data),
        .Pixel_Valid(Pixel_Valid), .Pixel_Data(Pixel_Data), .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
        .Frame_Start(Frame_Start), .Frame_Done(Frame_Done), .Frame_Err(Frame_Err),
        .Frame_Cnt(Frame_Cnt), .Capturing(Capturing)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [15:0] dat; logic [11:0] x; logic [11:0] y; logic st; int cyc; } pix_t;
    typedef struct { logic err; logic [15:0] cnt; } frm_t;
    typedef struct { int nlines; int bad_line; int bad_len; bit trunc; bit exp_err; } vec_t;

    pix_t exp_pix[$], got_pix[$];
    frm_t exp_frm[$], got_frm[$];

    int n_cmp = 0;
    int n_bad = 0;
    int pcyc  = 0;

    // Model state: where the driven stream sits relative to the capture window.
    int          pulses;
    bit          cap;
    logic [15:0] exp_cnt;
    int          line_idx;
    int          line_lens[$];
    logic [7:0]  fidx;
    bit          rnd;
    logic [7:0]  ovr[$];

    always @(posedge Clk) pcyc <= pcyc + 1;

    always @(negedge Clk) begin
        if (Pixel_Valid) got_pix.push_back('{Pixel_Data, Pixel_X, Pixel_Y, Frame_Start, pcyc});
        if (Frame_Done)  got_frm.push_back('{Frame_Err, Frame_Cnt});
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge Clk);
        camera_vsync = vs;
        camera_href  = hr;
        camera_data  = d;
    endtask

    // Drive n line bytes; each completed byte pair is an expected pixel two edges after its low byte.
    task automatic send_bytes(input int n);
        logic [7:0] hi, b;
        pix_t p;
        hi = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (ovr.size() > 0) b = ovr.pop_front();
            else if (rnd)       b = 8'($urandom);
            else                b = fidx;
            fidx = fidx + 8'd1;
            drv(1'b0, 1'b1, b);
            if (k % 2 == 0) hi = b;
            else if (cap) begin
                p.dat = {hi, b};
                p.x   = 12'(k / 2);
                p.y   = 12'(line_idx);
                p.st  = (k == 1) && (line_idx == 0);
                p.cyc = pcyc + 2;
                exp_pix.push_back(p);
            end
        end
    endtask

    task automatic send_line(input int n, input bit trunc);
        send_bytes(n);
        line_lens.push_back(n);
        line_idx++;
        if (!trunc) repeat (3) drv(1'b0, 1'b0, 8'h00);
    endtask

    // Vertical blanking pulse; closes the captured frame in the model and advances the skip count.
    task automatic vs_pulse(input logic hold_hr);
        frm_t f;
        drv(1'b1, hold_hr, 8'h00);
        drv(1'b1, 1'b0, 8'h00);
        drv(1'b1, 1'b0, 8'h00);
        drv(1'b0, 1'b0, 8'h00);
        drv(1'b0, 1'b0, 8'h00);
        if (cap) begin
            f.err = (line_lens.size() != H);
            foreach (line_lens[i]) if (line_lens[i] != 2 * W) f.err = 1'b1;
            exp_cnt = exp_cnt + 16'd1;
            f.cnt   = exp_cnt;
            exp_frm.push_back(f);
        end
        if (Init_Done) begin
            pulses++;
            cap = (pulses > SKIP);
        end
        line_lens.delete();
        line_idx = 0;
        fidx     = 8'h00;
    endtask

    task automatic send_frame(input int nl, input int bad_line, input int bad_len, input bit trunc);
        for (int l = 0; l < nl; l++)
            send_line((l == bad_line) ? bad_len : 2 * W, trunc && (l == nl - 1));
        vs_pulse(trunc);
    endtask

    task automatic random_frames(input int nf);
        int nl, n;
        bit tr;
        for (int f = 0; f < nf; f++) begin
            nl = $urandom_range(5, 3);
            tr = ($urandom_range(3, 0) == 0);
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(5, 0))
                    0:       n = $urandom_range(20, 1);
                    1:       n = 15;
                    2:       n = 18;
                    default: n = 2 * W;
                endcase
                send_line(n, tr && (l == nl - 1));
            end
            vs_pulse(tr);
        end
    endtask

    task automatic model_restart();
        cap      = 1'b0;
        pulses   = 0;
        line_idx = 0;
        fidx     = 8'h00;
        line_lens.delete();
    endtask

    task automatic check_queues(input string tag);
        chk({tag, " pixel count"}, 32'(got_pix.size()), 32'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
            chk($sformatf("%s pix%0d data", tag, i), 32'(got_pix[i].dat), 32'(exp_pix[i].dat));
            chk($sformatf("%s pix%0d x", tag, i), 32'(got_pix[i].x), 32'(exp_pix[i].x));
            chk($sformatf("%s pix%0d y", tag, i), 32'(got_pix[i].y), 32'(exp_pix[i].y));
            chk($sformatf("%s pix%0d start", tag, i), 32'(got_pix[i].st), 32'(exp_pix[i].st));
            chk($sformatf("%s pix%0d cycle", tag, i), 32'(got_pix[i].cyc), 32'(exp_pix[i].cyc));
        end
        chk({tag, " frame count"}, 32'(got_frm.size()), 32'(exp_frm.size()));
        for (int i = 0; i < exp_frm.size() && i < got_frm.size(); i++) begin
            chk($sformatf("%s frm%0d err", tag, i), 32'(got_frm[i].err), 32'(exp_frm[i].err));
            chk($sformatf("%s frm%0d cnt", tag, i), 32'(got_frm[i].cnt), 32'(exp_frm[i].cnt));
        end
        exp_pix.delete(); got_pix.delete();
        exp_frm.delete(); got_frm.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " Pixel_Valid"}, 32'(Pixel_Valid), 0);
        chk({tag, " Pixel_Data"},  32'(Pixel_Data), 0);
        chk({tag, " Pixel_X"},     32'(Pixel_X), 0);
        chk({tag, " Pixel_Y"},     32'(Pixel_Y), 0);
        chk({tag, " Frame_Start"}, 32'(Frame_Start), 0);
        chk({tag, " Frame_Done"},  32'(Frame_Done), 0);
        chk({tag, " Frame_Err"},   32'(Frame_Err), 0);
        chk({tag, " Frame_Cnt"},   32'(Frame_Cnt), 0);
        chk({tag, " Capturing"},   32'(Capturing), 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4, -1,  0, 1'b0, 1'b0};   // clean frame
        vecs[1] = '{4,  2, 15, 1'b0, 1'b1};   // odd byte count on line 2
        vecs[2] = '{4, -1,  0, 1'b0, 1'b0};   // clean frame after an error
        vecs[3] = '{3, -1,  0, 1'b0, 1'b1};   // short frame
        vecs[4] = '{5, -1,  0, 1'b0, 1'b1};   // tall frame
        vecs[5] = '{4,  0, 18, 1'b0, 1'b1};   // pixel beyond the line width
        vecs[6] = '{4,  3, 14, 1'b0, 1'b1};   // short line
        vecs[7] = '{4, -1,  0, 1'b1, 1'b0};   // vsync with href high, sizes still match
        vecs[8] = '{4,  3, 10, 1'b1, 1'b1};   // truncated last line

        Rst = 1'b1; Init_Done = 1'b0;
        camera_vsync = 1'b0; camera_href = 1'b0; camera_data = 8'h00;
        exp_cnt = 16'd0; rnd = 1'b0;
        model_restart();
        repeat (3) @(negedge Clk);
        chk_idle("reset");
        Rst = 1'b0;

        // Nominal: skip two frames, capture the next two.
        Init_Done = 1'b1;
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0);
        repeat (4) send_frame(H, -1, 0, 1'b0);
        chk("nominal pixel total", 32'(got_pix.size()), 64);
        if (got_pix.size() > 0) chk("nominal first pixel", 32'(got_pix[0].dat), 32'h0001);
        chk("nominal Frame_Cnt", 32'(Frame_Cnt), 2);
        chk("nominal Capturing", 32'(Capturing), 1);
        check_queues("nominal");

        // Latency: 0xAB then 0xCD at the start of a frame.
        ovr.push_back(8'hAB);
        ovr.push_back(8'hCD);
        send_frame(H, -1, 0, 1'b0);
        if (got_pix.size() > 0) chk("latency data", 32'(got_pix[0].dat), 32'hABCD);
        check_queues("latency");

        // Frame-shape table.
        foreach (vecs[i]) begin
            send_frame(vecs[i].nlines, vecs[i].bad_line, vecs[i].bad_len, vecs[i].trunc);
            chk($sformatf("vec%0d done pulses", i), 32'(got_frm.size()), 1);
            if (got_frm.size() > 0)
                chk($sformatf("vec%0d Frame_Err", i), 32'(got_frm[0].err), 32'(vecs[i].exp_err));
            check_queues($sformatf("vec%0d", i));
        end

        // Random frame shapes and data.
        rnd = 1'b1;
        random_frames(8);
        rnd = 1'b0;
        check_queues("random");

        // Init abort mid-line.
        send_line(2 * W, 1'b0);
        send_line(2 * W, 1'b0);
        send_bytes(6);
        drv(1'b0, 1'b1, 8'h55);
        drv(1'b0, 1'b1, 8'h66);
        Init_Done = 1'b0;
        drv(1'b0, 1'b0, 8'h00);
        chk("abort Capturing", 32'(Capturing), 0);
        model_restart();
        repeat (3) drv(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0);
        chk("abort no Frame_Done", 32'(got_frm.size()), 0);
        chk("abort Frame_Cnt", 32'(Frame_Cnt), 32'(exp_cnt));
        Init_Done = 1'b1;
        repeat (2) drv(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0);
        repeat (4) send_frame(H, -1, 0, 1'b0);
        check_queues("abort");

        // Synchronous reset mid-line.
        send_line(2 * W, 1'b0);
        send_bytes(4);
        drv(1'b0, 1'b1, 8'h55);
        drv(1'b0, 1'b1, 8'h66);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk_idle("mid reset");
        exp_cnt = 16'd0;
        model_restart();
        drv(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0);
        repeat (3) send_frame(H, -1, 0, 1'b0);
        chk("after reset Frame_Cnt", 32'(Frame_Cnt), 1);
        check_queues("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
